// File: rtl/lfsr_tick_gen_if.sv
// -----------------------------------------------------------------------------
// lfsr_tick_gen_if
// Bundles the data/control signals of lfsr_tick_gen so the producer side
// (divider clock, register-interface controls) and the generator can be
// connected with one port.
//
// Signals:
//   div_clk      divided clock, asynchronous to the generator's clk
//   enable       1 = detected div_clk edges step the LFSR
//   seed_load    one-cycle strobe, loads seed into the state
//   seed         seed value, sampled with seed_load
//   taps         Galois feedback mask, sampled on every step
//   clear_lockup one-cycle strobe, clears the sticky lockup flag
//   lfsr_out     current LFSR state
//   bit_out      copy of lfsr_out[0]
//   step_valid   one-cycle pulse when a stepped state first appears
//   step_count   steps since reset / seed_load (wraps)
//   lockup       sticky: a zero state was replaced by DEFAULT_SEED
//   armed        debug view of the edge-detect arm state
//
// Modports: master drives the controls, slave is the generator.
// -----------------------------------------------------------------------------
interface lfsr_tick_gen_if #(
    parameter int WIDTH = 16
);
    logic             div_clk;
    logic             enable;
    logic             seed_load;
    logic [WIDTH-1:0] seed;
    logic [WIDTH-1:0] taps;
    logic             clear_lockup;
    logic [WIDTH-1:0] lfsr_out;
    logic             bit_out;
    logic             step_valid;
    logic [31:0]      step_count;
    logic             lockup;
    logic             armed;

    modport master (
        output div_clk, enable, seed_load, seed, taps, clear_lockup,
        input  lfsr_out, bit_out, step_valid, step_count, lockup, armed
    );

    modport slave (
        input  div_clk, enable, seed_load, seed, taps, clear_lockup,
        output lfsr_out, bit_out, step_valid, step_count, lockup, armed
    );
endinterface

// File: rtl/lfsr_tick_gen.sv
// -----------------------------------------------------------------------------
// lfsr_tick_gen
// Synchronises the divider's output clock into clk, detects its rising edges
// and advances a Galois LFSR once per detected edge. Reports the state, its
// LSB, a step pulse, a step counter and a sticky lock-up flag.
//
// Ports:
//   clk    system clock
//   reset  asynchronous, active-high reset
//   bus    lfsr_tick_gen_if.slave (see the interface file for signals);
//          the interface instance must use the same WIDTH as this module
//
// Handshake: there is no back-pressure. A step is taken in the clk cycle where
// a synchronised div_clk rising edge is seen while armed and enable=1 and
// seed_load=0; step_valid is high for exactly that one cycle after the new
// state is registered. seed_load wins over a coincident tick, which is lost.
//
// Latency: a div_clk rise captured at clk edge N shows on lfsr_out and
// step_valid at edge N+SYNC_STAGES.
// -----------------------------------------------------------------------------
module lfsr_tick_gen #(
    parameter int               WIDTH        = 16,
    parameter logic [WIDTH-1:0] DEFAULT_SEED = WIDTH'(16'hACE1),
    parameter int               SYNC_STAGES  = 2
) (
    input  logic          clk,
    input  logic          reset,
    lfsr_tick_gen_if.slave bus
);

    // Edge detection stays off for SYNC_STAGES+1 cycles after reset so the
    // previous-sample flop has caught up with a div_clk that was already high.
    localparam int ARM_CYCLES = SYNC_STAGES + 1;
    localparam int CNT_W      = $clog2(ARM_CYCLES + 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic [CNT_W-1:0]       r_arm_cnt;
    logic [WIDTH-1:0]       r_state;
    logic                   r_bit;
    logic                   r_step_valid;
    logic [31:0]            r_step_count;
    logic                   r_lockup;

    logic                   w_sync_out;
    logic                   w_armed;
    logic                   w_tick;
    logic [WIDTH-1:0]       w_shift;
    logic [WIDTH-1:0]       w_state_nxt;
    logic [31:0]            w_count_nxt;
    logic                   w_valid_nxt;
    logic                   w_lock_set;

    assign w_sync_out = r_sync[SYNC_STAGES-1];
    assign w_armed    = (r_arm_cnt == CNT_W'(ARM_CYCLES));
    assign w_tick     = w_sync_out & ~r_prev & w_armed;

    // Synchroniser, previous-sample flop and arm counter. r_prev always
    // follows the synchroniser, armed or not.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync    <= '0;
            r_prev    <= 1'b0;
            r_arm_cnt <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], bus.div_clk};
            r_prev <= w_sync_out;
            if (!w_armed) begin
                r_arm_cnt <= r_arm_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        // Right-shift Galois step: feedback applied when the bit shifted out is 1.
        w_shift     = r_state[0] ? ((r_state >> 1) ^ bus.taps) : (r_state >> 1);
        w_state_nxt = r_state;
        w_count_nxt = r_step_count;
        w_valid_nxt = 1'b0;
        w_lock_set  = 1'b0;
        if (bus.seed_load) begin
            w_count_nxt = 32'd0;
            if (bus.seed == '0) begin
                w_state_nxt = DEFAULT_SEED;
                w_lock_set  = 1'b1;
            end else begin
                w_state_nxt = bus.seed;
            end
        end else if (w_tick && bus.enable) begin
            w_count_nxt = r_step_count + 32'd1;
            w_valid_nxt = 1'b1;
            // An all-zero state would never leave zero; substitute the seed.
            if (w_shift == '0) begin
                w_state_nxt = DEFAULT_SEED;
                w_lock_set  = 1'b1;
            end else begin
                w_state_nxt = w_shift;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= DEFAULT_SEED;
            r_bit        <= DEFAULT_SEED[0];
            r_step_valid <= 1'b0;
            r_step_count <= 32'd0;
            r_lockup     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_bit        <= w_state_nxt[0];
            r_step_valid <= w_valid_nxt;
            r_step_count <= w_count_nxt;
            // Setting wins over a same-cycle clear.
            if (w_lock_set) begin
                r_lockup <= 1'b1;
            end else if (bus.clear_lockup) begin
                r_lockup <= 1'b0;
            end
        end
    end

    assign bus.lfsr_out   = r_state;
    assign bus.bit_out    = r_bit;
    assign bus.step_valid = r_step_valid;
    assign bus.step_count = r_step_count;
    assign bus.lockup     = r_lockup;
    assign bus.armed      = w_armed;

endmodule

// File: tb/tb_lfsr_tick_gen.sv
module tb_lfsr_tick_gen;

    logic clk;
    logic reset;

    int n_tests    = 0;
    int n_fail     = 0;
    int pulse_cnt  = 0;
    int exp_pulses = 0;

    lfsr_tick_gen_if #(.WIDTH(16)) bus ();
    lfsr_tick_gen_if #(.WIDTH(4))  bus4 ();

    // The narrow instance shares the divided clock with the main one.
    assign bus4.div_clk = bus.div_clk;

    lfsr_tick_gen #(
        .WIDTH        (16),
        .DEFAULT_SEED (16'hACE1),
        .SYNC_STAGES  (2)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    lfsr_tick_gen #(
        .WIDTH        (4),
        .DEFAULT_SEED (4'h9),
        .SYNC_STAGES  (2)
    ) u_dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4.slave)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count every sampled step_valid cycle of the main instance.
    always @(negedge clk) begin
        if (bus.step_valid === 1'b1) pulse_cnt++;
    end

    // Hand-computed sequences.
    // 16-bit, taps 0xB400, from seed 0x0001.
    logic [15:0] tbl16 [10] = '{16'hB400, 16'h5A00, 16'h2D00, 16'h1680, 16'h0B40,
                                16'h05A0, 16'h02D0, 16'h0168, 16'h00B4, 16'h005A};
    // 4-bit, taps 0xC, from seed 0x1: full period of 15.
    logic [3:0] tbl4 [15] = '{4'hC, 4'h6, 4'h3, 4'hD, 4'hA, 4'h5, 4'hE, 4'h7,
                              4'hF, 4'hB, 4'h9, 4'h8, 4'h4, 4'h2, 4'h1};

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- drivers ----------------
    // One div_clk rising edge; checks step_valid stays low for two cycles and
    // matches exp_step on the third sample after the rise.
    task automatic div_edge(input string tag, input logic exp_step);
        @(negedge clk) bus.div_clk = 1'b1;
        @(negedge clk);
        check({tag, "_lat1"}, {31'd0, bus.step_valid}, 32'd0);
        @(negedge clk);
        check({tag, "_lat2"}, {31'd0, bus.step_valid}, 32'd0);
        @(negedge clk);
        check({tag, "_valid"}, {31'd0, bus.step_valid}, {31'd0, exp_step});
        if (exp_step) exp_pulses++;
        bus.div_clk = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic load_seed(input logic [15:0] s);
        @(negedge clk);
        bus.seed      = s;
        bus.seed_load = 1'b1;
        @(negedge clk);
        bus.seed_load = 1'b0;
    endtask

    task automatic clear_strobe();
        @(negedge clk) bus.clear_lockup = 1'b1;
        @(negedge clk) bus.clear_lockup = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset             = 1'b1;
        bus.div_clk       = 1'b1;
        bus.enable        = 1'b1;
        bus.seed_load     = 1'b0;
        bus.seed          = 16'h0000;
        bus.taps          = 16'hB400;
        bus.clear_lockup  = 1'b0;
        bus4.enable       = 1'b0;
        bus4.seed_load    = 1'b0;
        bus4.seed         = 4'h0;
        bus4.taps         = 4'hC;
        bus4.clear_lockup = 1'b0;

        // Reset values.
        @(negedge clk);
        check("rst_lfsr",  {16'd0, bus.lfsr_out}, 32'h0000ACE1);
        check("rst_bit",   {31'd0, bus.bit_out}, 32'd1);
        check("rst_valid", {31'd0, bus.step_valid}, 32'd0);
        check("rst_count", bus.step_count, 32'd0);
        check("rst_lock",  {31'd0, bus.lockup}, 32'd0);

        // Release with div_clk high: no step during arm window.
        @(negedge clk) reset = 1'b0;
        repeat (6) @(negedge clk);
        check("arm_lfsr",   {16'd0, bus.lfsr_out}, 32'h0000ACE1);
        check("arm_count",  bus.step_count, 32'd0);
        check("arm_pulses", pulse_cnt, 0);
        bus.div_clk = 1'b0;
        repeat (2) @(negedge clk);

        // Three steps from the default seed.
        div_edge("s1", 1'b1);
        check("s1_lfsr", {16'd0, bus.lfsr_out}, 32'h0000E270);
        check("s1_bit",  {31'd0, bus.bit_out}, 32'd0);
        div_edge("s2", 1'b1);
        check("s2_lfsr", {16'd0, bus.lfsr_out}, 32'h00007138);
        div_edge("s3", 1'b1);
        check("s3_lfsr",   {16'd0, bus.lfsr_out}, 32'h0000389C);
        check("s3_count",  bus.step_count, 32'd3);
        check("s3_pulses", pulse_cnt, exp_pulses);

        // seed_load coincident with a tick: tick is dropped.
        @(negedge clk) bus.div_clk = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.seed      = 16'h1234;
        bus.seed_load = 1'b1;
        @(negedge clk);
        bus.seed_load = 1'b0;
        check("coin_lfsr",  {16'd0, bus.lfsr_out}, 32'h00001234);
        check("coin_count", bus.step_count, 32'd0);
        check("coin_valid", {31'd0, bus.step_valid}, 32'd0);
        bus.div_clk = 1'b0;
        repeat (3) @(negedge clk);
        check("coin_pulses", pulse_cnt, exp_pulses);
        check("coin_hold",   {16'd0, bus.lfsr_out}, 32'h00001234);

        // Zero seed with a same-cycle clear: substitution and lockup wins.
        @(negedge clk);
        bus.seed         = 16'h0000;
        bus.seed_load    = 1'b1;
        bus.clear_lockup = 1'b1;
        @(negedge clk);
        bus.seed_load    = 1'b0;
        bus.clear_lockup = 1'b0;
        check("zs_lfsr", {16'd0, bus.lfsr_out}, 32'h0000ACE1);
        check("zs_lock", {31'd0, bus.lockup}, 32'd1);
        clear_strobe();
        check("zs_clear", {31'd0, bus.lockup}, 32'd0);

        // taps=0 from seed 1: next state zero is substituted.
        bus.taps = 16'h0000;
        load_seed(16'h0001);
        check("lk_seed", {16'd0, bus.lfsr_out}, 32'h00000001);
        check("lk_lock0", {31'd0, bus.lockup}, 32'd0);
        div_edge("lk", 1'b1);
        check("lk_lfsr",  {16'd0, bus.lfsr_out}, 32'h0000ACE1);
        check("lk_lock1", {31'd0, bus.lockup}, 32'd1);
        check("lk_count", bus.step_count, 32'd1);
        clear_strobe();
        check("lk_clear", {31'd0, bus.lockup}, 32'd0);

        // enable low: edges discarded, then exactly one step.
        bus.taps   = 16'hB400;
        bus.enable = 1'b0;
        for (int i = 0; i < 5; i++) div_edge("en0", 1'b0);
        check("en0_lfsr",   {16'd0, bus.lfsr_out}, 32'h0000ACE1);
        check("en0_count",  bus.step_count, 32'd1);
        check("en0_pulses", pulse_cnt, exp_pulses);
        bus.enable = 1'b1;
        div_edge("en1", 1'b1);
        check("en1_lfsr",   {16'd0, bus.lfsr_out}, 32'h0000E270);
        check("en1_count",  bus.step_count, 32'd2);
        check("en1_pulses", pulse_cnt, exp_pulses);

        // 16-bit walk from seed 1 with taps 0xB400.
        load_seed(16'h0001);
        check("w16_count0", bus.step_count, 32'd0);
        for (int i = 0; i < 10; i++) begin
            div_edge("w16", 1'b1);
            check("w16_lfsr",  {16'd0, bus.lfsr_out}, {16'd0, tbl16[i]});
            check("w16_bit",   {31'd0, bus.bit_out}, {31'd0, tbl16[i][0]});
            check("w16_count", bus.step_count, i + 1);
        end
        check("w16_lock", {31'd0, bus.lockup}, 32'd0);

        // 4-bit instance: full period, returns to seed only at step 15.
        bus.enable = 1'b0;
        @(negedge clk);
        bus4.seed      = 4'h1;
        bus4.seed_load = 1'b1;
        bus4.enable    = 1'b1;
        @(negedge clk);
        bus4.seed_load = 1'b0;
        for (int i = 0; i < 15; i++) begin
            div_edge("w4", 1'b0);
            check("w4_lfsr",  {28'd0, bus4.lfsr_out}, {28'd0, tbl4[i]});
            check("w4_count", bus4.step_count, i + 1);
        end
        check("w4_lock", {31'd0, bus4.lockup}, 32'd0);
        bus4.enable = 1'b0;
        bus.enable  = 1'b1;
        check("w16_hold", {16'd0, bus.lfsr_out}, 32'h0000005A);

        // Asynchronous reset mid-run, with lockup set first.
        @(negedge clk);
        bus.seed      = 16'h0000;
        bus.seed_load = 1'b1;
        @(negedge clk);
        bus.seed_load = 1'b0;
        load_seed(16'h0001);
        for (int i = 0; i < 10; i++) div_edge("mr", 1'b1);
        check("mr_count", bus.step_count, 32'd10);
        check("mr_lfsr",  {16'd0, bus.lfsr_out}, 32'h0000005A);
        check("mr_lock",  {31'd0, bus.lockup}, 32'd1);
        @(posedge clk);
        #2;
        reset       = 1'b1;
        bus.div_clk = 1'b1;
        #1;
        check("ar_lfsr",  {16'd0, bus.lfsr_out}, 32'h0000ACE1);
        check("ar_count", bus.step_count, 32'd0);
        check("ar_valid", {31'd0, bus.step_valid}, 32'd0);
        check("ar_lock",  {31'd0, bus.lockup}, 32'd0);
        @(negedge clk) reset = 1'b0;
        repeat (6) @(negedge clk);
        check("ar_arm_lfsr", {16'd0, bus.lfsr_out}, 32'h0000ACE1);
        check("ar_arm_cnt",  bus.step_count, 32'd0);
        bus.div_clk = 1'b0;
        repeat (2) @(negedge clk);
        div_edge("ar", 1'b1);
        check("ar_step_lfsr",  {16'd0, bus.lfsr_out}, 32'h0000E270);
        check("ar_step_count", bus.step_count, 32'd1);
        repeat (2) @(negedge clk);
        check("end_pulses", pulse_cnt, exp_pulses);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
